// File: rtl/qar_sum_master.sv
// qar_sum_master: reads `count` words from base_addr, sums the non-negative ones
// (bit 31 clear) modulo 2^32, then stores the sum to dest_addr.
// Optional feature: define QAR_SUM_TIMEOUT_EN to abort a stalled memory request after
// TIMEOUT_CYCLES wait cycles (done + error, no store).
module qar_sum_master #(
  parameter int unsigned CNT_WIDTH      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [31:0]          base_addr,
  input  logic [CNT_WIDTH-1:0] count,
  input  logic [31:0]          dest_addr,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [31:0]          sum,
  output logic                 mem_valid,
  output logic                 mem_we,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic                 mem_ready,
  input  logic [31:0]          mem_rdata
);

  typedef enum logic [2:0] {StIdle, StRead, StGap, StWrite, StDone} state_e;

  state_e               state_q, state_d;
  logic [29:0]          base_q, base_d;
  logic [29:0]          dest_q, dest_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [CNT_WIDTH-1:0] idx_q, idx_d;
  logic [31:0]          sum_q, sum_d;
  logic                 timeout;

  // Byte-lane bits of the addresses are dropped; all accesses are word aligned.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{base_addr[1:0], dest_addr[1:0]};

`ifdef QAR_SUM_TIMEOUT_EN
  logic [7:0] wait_q, wait_d;
  logic       err_q, err_d;

  // Wait counter advances only while a request is outstanding; cleared otherwise.
  always_comb begin
    wait_d  = 8'd0;
    timeout = 1'b0;
    if ((state_q == StRead || state_q == StWrite) && !mem_ready) begin
      wait_d  = wait_q + 8'd1;
      timeout = (wait_q == 8'(TIMEOUT_CYCLES - 1));
    end
  end

  // Timeout bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= 8'd0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      err_q  <= err_d;
    end
  end

  assign error = (state_q == StDone) && err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
  assign error              = 1'b0;
`endif

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    dest_d  = dest_q;
    count_d = count_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
`ifdef QAR_SUM_TIMEOUT_EN
    err_d   = err_q;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          base_d  = base_addr[31:2];
          dest_d  = dest_addr[31:2];
          count_d = count;
          idx_d   = '0;
          sum_d   = 32'd0;
`ifdef QAR_SUM_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = (count == '0) ? StWrite : StRead;
        end
      end
      StRead: begin
        if (mem_ready) begin
          if (!mem_rdata[31]) sum_d = sum_q + mem_rdata;
          idx_d   = idx_q + 1'b1;
          state_d = StGap;
        end else if (timeout) begin
`ifdef QAR_SUM_TIMEOUT_EN
          err_d   = 1'b1;
`endif
          state_d = StDone;
        end
      end
      StGap: begin
        state_d = (idx_q == count_q) ? StWrite : StRead;
      end
      StWrite: begin
        if (mem_ready) begin
          state_d = StDone;
        end else if (timeout) begin
`ifdef QAR_SUM_TIMEOUT_EN
          err_d   = 1'b1;
`endif
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      base_q  <= '0;
      dest_q  <= '0;
      count_q <= '0;
      idx_q   <= '0;
      sum_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      dest_q  <= dest_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
    end
  end

  // Outputs decode from registered state only, so reset clears them without a clock.
  always_comb begin
    busy      = (state_q == StRead) || (state_q == StGap) || (state_q == StWrite);
    done      = (state_q == StDone);
    mem_valid = (state_q == StRead) || (state_q == StWrite);
    mem_we    = (state_q == StWrite);
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    if (state_q == StRead) begin
      mem_addr = {base_q + 30'(idx_q), 2'b00};
    end else if (state_q == StWrite) begin
      mem_addr  = {dest_q, 2'b00};
      mem_wdata = sum_q;
    end
  end

  assign sum = sum_q;

endmodule

// File: tb/tb_qar_sum_master.sv
// Self-checking bench for qar_sum_master: a cycle-level memory responder with
// programmable wait states and a scoreboard of expected bus transactions.
module tb_qar_sum_master;

  localparam int CW = 8;
  localparam int TO = 255;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   base_addr = '0;
  logic [CW-1:0] count = '0;
  logic [31:0]   dest_addr = '0;
  logic          busy, done, error, mem_valid, mem_we;
  logic [31:0]   sum, mem_addr, mem_wdata;
  logic          mem_ready = 1'b0;
  logic [31:0]   mem_rdata = '0;

  int total = 0;
  int bad   = 0;

  logic [31:0] words[16];
  logic [31:0] q_addr[$];
  logic        q_we[$];
  logic [31:0] q_data[$];

  qar_sum_master #(.CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
    .dest_addr(dest_addr), .busy(busy), .done(done), .error(error), .sum(sum),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Runs one job. rst_at >= 0: assert reset on the first wait cycle of that read.
  // stall_at >= 0: never answer that read (timeout build only).
  task automatic run_job(input int n, input logic [31:0] base, input logic [31:0] dest,
                         input int maxwait, input int rst_at, input int stall_at);
    logic [31:0] exp_sum, s_addr, s_wdata, ea, ed;
    logic        exp_err, prev_hs, hs, s_we, ewe;
    int          cnt, w, reads, cyc, stall_cycles;
    exp_sum = 0; exp_err = (stall_at >= 0); prev_hs = 0;
    cnt = 0; reads = 0; cyc = 0; stall_cycles = 0;
    s_addr = 0; s_wdata = 0; s_we = 0;
    q_addr.delete(); q_we.delete(); q_data.delete();
    for (int k = 0; k < n; k++) begin
      if (stall_at >= 0 && k >= stall_at) break;
      q_addr.push_back((base & 32'hFFFF_FFFC) + 32'(4 * k));
      q_we.push_back(1'b0);
      q_data.push_back(32'd0);
      if (!words[k][31]) exp_sum = exp_sum + words[k];
    end
    if (stall_at < 0) begin
      q_addr.push_back(dest & 32'hFFFF_FFFC);
      q_we.push_back(1'b1);
      q_data.push_back(exp_sum);
    end
    w = $urandom_range(maxwait, 0);
    @(negedge clk);
    base_addr = base; dest_addr = dest; count = CW'(n); start = 1'b1;
    forever begin
      @(negedge clk);
      cyc++; hs = 1'b0; mem_ready = 1'b0; mem_rdata = $urandom;
      if (cyc == 1) start = 1'b0;
      if (cyc == 2) begin
        start = 1'b1; base_addr = 32'h5550; count = 3; dest_addr = 32'h9990;
      end
      if (cyc == 3) start = 1'b0;
      if (mem_valid) begin
        total++;
        if (prev_hs) begin
          bad++;
          $display("FAIL gap: mem_valid=%b right after handshake, required 0", mem_valid);
        end
        if (cnt == 0) begin
          s_addr = mem_addr; s_we = mem_we; s_wdata = mem_wdata;
          if (rst_at >= 0 && reads == rst_at && !mem_we) begin
            rst_n = 1'b0;
            #1;
            total++;
            if ({busy, done, error, mem_valid, mem_we} !== 5'b0 || mem_addr !== 0 ||
                mem_wdata !== 0 || sum !== 0) begin
              bad++;
              $display("FAIL async_reset: ctl=%b addr=%h wdata=%h sum=%h, required all 0",
                       {busy, done, error, mem_valid, mem_we}, mem_addr, mem_wdata, sum);
            end
            q_addr.delete(); q_we.delete(); q_data.delete();
            mem_ready = 1'b0;
            return;
          end
        end else begin
          total++;
          if (mem_addr !== s_addr || mem_we !== s_we || mem_wdata !== s_wdata) begin
            bad++;
            $display("FAIL stable: addr=%h we=%b wdata=%h, required addr=%h we=%b wdata=%h",
                     mem_addr, mem_we, mem_wdata, s_addr, s_we, s_wdata);
          end
        end
        if (stall_at >= 0 && reads == stall_at && !mem_we) begin
          stall_cycles++;
          cnt++;
        end else if (cnt == w + 1) begin
          hs = 1'b1; mem_ready = 1'b1; cnt = 0; w = $urandom_range(maxwait, 0);
          total++;
          if (q_addr.size() == 0) begin
            bad++;
            $display("FAIL xact: unexpected addr=%h we=%b, required no transaction",
                     mem_addr, mem_we);
          end else begin
            ea = q_addr.pop_front(); ewe = q_we.pop_front(); ed = q_data.pop_front();
            if (mem_addr !== ea || mem_we !== ewe || (ewe && mem_wdata !== ed)) begin
              bad++;
              $display("FAIL xact: addr=%h we=%b wdata=%h, required addr=%h we=%b wdata=%h",
                       mem_addr, mem_we, mem_wdata, ea, ewe, ed);
            end
          end
          if (!mem_we) begin
            mem_rdata = words[reads];
            reads++;
          end
        end else begin
          cnt++;
        end
      end else if (maxwait > 0) begin
        mem_ready = 1'($urandom_range(1, 0)); // stray strobe must be ignored
      end
      prev_hs = hs;
      if (done) begin
        total++;
        if (sum !== exp_sum) begin
          bad++;
          $display("FAIL sum: got %h, required %h", sum, exp_sum);
        end
        total++;
        if (error !== exp_err) begin
          bad++;
          $display("FAIL error: got %b, required %b", error, exp_err);
        end
        total++;
        if (q_addr.size() != 0) begin
          bad++;
          $display("FAIL missing: %0d transactions outstanding, required 0", q_addr.size());
        end
        total++;
        if (busy !== 1'b0) begin
          bad++;
          $display("FAIL busy_in_done: got %b, required 0", busy);
        end
        if (stall_at >= 0) begin
          total++;
          if (stall_cycles != TO) begin
            bad++;
            $display("FAIL timeout_len: got %0d wait cycles, required %0d", stall_cycles, TO);
          end
        end
        start = 1'b1; base_addr = 32'h7770; count = 2; dest_addr = 32'h8880;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || mem_valid !== 1'b0) begin
          bad++;
          $display("FAIL after_done: done=%b busy=%b valid=%b, required 0 0 0",
                   done, busy, mem_valid);
        end
        repeat (3) @(negedge clk);
        total++;
        if (sum !== exp_sum || busy !== 1'b0 || mem_valid !== 1'b0) begin
          bad++;
          $display("FAIL hold: sum=%h busy=%b valid=%b, required sum=%h busy=0 valid=0",
                   sum, busy, mem_valid, exp_sum);
        end
        return;
      end
      if (cyc > 3000) begin
        total++; bad++;
        $display("FAIL no_done: done=%b after %0d cycles, required 1", done, cyc);
        start = 1'b0;
        return;
      end
    end
  endtask

  task automatic load_main_words();
    words[0] = 32'd5;        words[1] = 32'hFFFF_FFFF; words[2] = 32'd10;
    words[3] = 32'h8000_0000; words[4] = 32'd7;         words[5] = 32'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, error, mem_valid, mem_we} !== 5'b0 || mem_addr !== 0 ||
        mem_wdata !== 0 || sum !== 0) begin
      bad++;
      $display("FAIL reset: ctl=%b addr=%h wdata=%h sum=%h, required all 0",
               {busy, done, error, mem_valid, mem_we}, mem_addr, mem_wdata, sum);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    load_main_words();
    run_job(6, 32'h0, 32'h40, 0, -1, -1);
  endtask

  task automatic test_wait_states();
    load_main_words();
    run_job(6, 32'h0, 32'h40, 3, -1, -1);
  endtask

  task automatic test_zero_count();
    run_job(0, 32'h1000, 32'h80, 0, -1, -1);
    run_job(0, 32'h1000, 32'h80, 3, -1, -1);
  endtask

  task automatic test_wrap();
    words[0] = 32'h7FFF_FFFF; words[1] = 32'h7FFF_FFFF;
    run_job(2, 32'hFFFF_FFFC, 32'h10, 2, -1, -1);
  endtask

  task automatic test_unaligned();
    words[0] = 32'h1234; words[1] = 32'h8000_0001; words[2] = 32'h0FFF_0000;
    run_job(3, 32'h1003, 32'h2042, 3, -1, -1);
  endtask

  task automatic test_reset_mid();
    load_main_words();
    run_job(6, 32'h0, 32'h40, 2, 2, -1);
    repeat (2) @(negedge clk);
    total++;
    if (mem_valid !== 1'b0 || busy !== 1'b0 || sum !== 0) begin
      bad++;
      $display("FAIL held_reset: valid=%b busy=%b sum=%h, required 0 0 0",
               mem_valid, busy, sum);
    end
    rst_n = 1'b1;
    @(negedge clk);
    run_job(6, 32'h200, 32'h44, 1, -1, -1);
  endtask

`ifdef QAR_SUM_TIMEOUT_EN
  task automatic test_timeout();
    words[0] = 32'd9; words[1] = 32'd4; words[2] = 32'd3;
    run_job(3, 32'h0, 32'h40, 1, -1, 1);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_wait_states();
    test_zero_count();
    test_wrap();
    test_unaligned();
    test_reset_mid();
`ifdef QAR_SUM_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qar_sum_master.md
QAR_SUM_MASTER -- requirements
Module: qar_sum_master

Interface
REQ-001 Parameter CNT_WIDTH, default 8: width of the word-count input.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: maximum cycles to wait for mem_ready (used only with QAR_SUM_TIMEOUT_EN).
REQ-003 The block SHALL use one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-004 Ports SHALL be as follows:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle job request
- base_addr  in  32  byte address of the first source word
- count  in  CNT_WIDTH  number of words to read
- dest_addr  in  32  byte address for the result store
- busy  out  1  job in progress
- done  out  1  one-cycle completion pulse
- error  out  1  one-cycle timeout pulse, coincident with done
- sum  out  32  accumulator
- mem_valid  out  1  request valid
- mem_we  out  1  1 = store, 0 = load
- mem_addr  out  32  word-aligned byte address
- mem_wdata  out  32  store data
- mem_ready  in  1  one-cycle response strobe
- mem_rdata  in  32  load data, valid when mem_ready = 1

Function
REQ-005 The state machine SHALL have the states IDLE, READ, GAP, WRITE and DONE.
REQ-006 IDLE: busy = 0; on start = 1, capture base_addr, count and dest_addr, clear sum and the index, and enter READ, or WRITE if count = 0.
REQ-007 start SHALL be ignored in every state other than IDLE.
REQ-008 READ: mem_valid = 1, mem_we = 0, mem_addr = {base[31:2] + idx, 2'b00}, modulo 2^32; base_addr[1:0] and dest_addr[1:0] are ignored.
REQ-009 In READ, on the edge where mem_ready = 1: if mem_rdata[31] = 0, sum <= sum + mem_rdata (mod 2^32), otherwise sum is unchanged; idx increments; next state is GAP.
REQ-010 GAP: mem_valid = 0 for exactly one cycle; next state is WRITE if idx = count, otherwise READ.
REQ-011 WRITE: mem_valid = 1, mem_we = 1, mem_addr = {dest[31:2], 2'b00}, mem_wdata = sum; on mem_ready the next state is DONE.
REQ-012 DONE: done = 1 for exactly one cycle, busy = 0, then IDLE; a start arriving in DONE is ignored.
REQ-013 Request stability: mem_addr, mem_we and mem_wdata SHALL remain constant while mem_valid = 1 and mem_ready = 0.
REQ-014 mem_valid SHALL deassert on the edge where mem_ready is sampled high.
REQ-015 At least one mem_valid = 0 cycle SHALL separate consecutive transactions.
REQ-016 mem_ready while mem_valid = 0 SHALL be ignored.
REQ-017 Zero wait states (mem_ready high one cycle after mem_valid rises) SHALL be supported, giving a minimum of 2 cycles per read plus 1 GAP cycle.
REQ-018 busy SHALL be 1 in READ, GAP and WRITE.
REQ-019 sum SHALL hold its final value after DONE until the next accepted start.

Reset
REQ-020 When rst_n = 0, asynchronously: state = IDLE; busy, done, error, mem_valid and mem_we = 0; mem_addr, mem_wdata, sum and idx = 0.
REQ-021 A reset mid-transaction SHALL drop mem_valid immediately and abandon the job, with no store issued.

Configuration
REQ-022 With QAR_SUM_TIMEOUT_EN defined, an 8-bit wait counter SHALL run while mem_valid = 1 and mem_ready = 0, clearing on each new request.
REQ-023 With QAR_SUM_TIMEOUT_EN defined, when the wait counter reaches TIMEOUT_CYCLES: mem_valid deasserts, the FSM enters DONE with error = 1, sum keeps its partial value, and no store is issued.
REQ-024 Without QAR_SUM_TIMEOUT_EN, error SHALL be tied to 0 and the block SHALL wait indefinitely for mem_ready.

Verification
REQ-025 base = 0x0, count = 6, words {5, 0xFFFFFFFF, 10, 0x80000000, 7, 0}, zero wait -> reads at 0x0..0x14, store of 22 to dest = 0x40, done pulse, sum = 22.
REQ-026 Same data with a random 0-3 wait states per transaction -> identical result; mem_addr and mem_wdata stable during every wait; no back-to-back mem_valid.
REQ-027 count = 0, dest = 0x80 -> no reads, a single store of 0 to 0x80, then done.
REQ-028 Words {0x7FFFFFFF, 0x7FFFFFFF} -> sum = 0xFFFFFFFE (mod-2^32 wrap, no saturation); base = 0xFFFFFFFC -> second read address wraps to 0x0.
REQ-029 rst_n low during the third read's wait -> all outputs 0 asynchronously, no store; a fresh start afterwards completes correctly.
REQ-030 QAR_SUM_TIMEOUT_EN defined, mem_ready never asserted on read 2 -> after 255 wait cycles done = 1 and error = 1, sum = word0 (if non-negative), no store.
